// File: rtl/mmio_timer.sv
// Memory-mapped interval timer: auto-reloading up-counter with sticky
// overflow interrupt and a free-running systick, decoded on the data bus.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        hit,
    output logic        irq
);

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [31:0] systick;
    logic [31:0] rdata;
    logic [2:0]  off;
    logic        wr;
    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic        ovf;
    logic        set_irq;
    logic        unused_addr;

    assign hit         = (Address[31:5] == BASE_ADDR[31:5]);
    assign off         = Address[4:2];
    assign unused_addr = ^Address[1:0];
    assign wr          = MemWrite && hit;
    assign wr_th       = wr && (off == 3'd0);
    assign wr_tl       = wr && (off == 3'd1);
    assign wr_tcon     = wr && (off == 3'd2);

    // A CPU store to TL suppresses both the increment and the reload.
    assign ovf     = tcon[0] && !wr_tl && (tl == 32'hFFFF_FFFF);
    assign set_irq = ovf && tcon[1];
    assign irq     = tcon[2];

    always_comb begin
        rdata = '0;
        case (off)
            3'd0:    rdata = th;
            3'd1:    rdata = tl;
            3'd2:    rdata = {29'b0, tcon};
            3'd5:    rdata = systick;
            default: rdata = '0;
        endcase
    end

    assign Read_data = (MemRead && hit) ? rdata : 32'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th      <= '0;
            tl      <= '0;
            tcon    <= '0;
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (wr_th)
                th <= Write_data;
            // Reload takes the pre-store TH when both land in one cycle.
            if (wr_tl)
                tl <= Write_data;
            else if (tcon[0])
                tl <= ovf ? th : tl + 32'd1;
            // Hardware set of the status bit beats a software clear.
            if (wr_tcon)
                tcon <= {Write_data[2] | set_irq, Write_data[1:0]};
            else if (set_irq)
                tcon[2] <= 1'b1;
        end
    end

endmodule
